// File: rtl/pwm_mixer_pkg.sv
// Shared defaults and helpers for the encoder-driven PWM mixer.
package pwm_mixer_pkg;

  localparam int DEF_NUM_CH      = 3;
  localparam int DEF_LEVEL_WIDTH = 8;
  localparam int DEF_STEP        = 1;
  localparam int DEF_DEBOUNCE    = 7;
  localparam int DEF_SATURATE    = 1;
  localparam int DEF_INVERT      = 0;
  localparam int DB_CNT_W        = 8;

  // Load-channel select width, never narrower than one bit.
  function automatic int ch_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mixer_channel.sv
// One encoder channel: synchronise, debounce, detent decode, level register.
module mixer_channel
  import pwm_mixer_pkg::*;
#(
  parameter int LEVEL_WIDTH     = DEF_LEVEL_WIDTH,
  parameter int STEP            = DEF_STEP,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int SATURATE        = DEF_SATURATE
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enc_a_i,
  input  logic                   enc_b_i,
  input  logic                   load_i,
  input  logic [LEVEL_WIDTH-1:0] load_level_i,
  output logic [LEVEL_WIDTH-1:0] level_o
);

  localparam int LW1 = LEVEL_WIDTH + 1;
  localparam logic [LW1-1:0] STEP_V = LW1'(STEP);
  localparam logic [DB_CNT_W-1:0] DB_MAX =
    DB_CNT_W'(DEBOUNCE_CYCLES - 1);

  // Bit 0 carries phase A, bit 1 phase B.
  logic [1:0] meta_q, sync_q;
  logic [1:0] deb_q, deb_d;
  logic [1:0][DB_CNT_W-1:0] cnt_q, cnt_d;
  logic a_prev_q;
  logic [LEVEL_WIDTH-1:0] level_q, level_d;
  logic [LW1-1:0] sum, diff;
  logic rise;

  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    for (int k = 0; k < 2; k++) begin
      if (sync_q[k] == deb_q[k]) begin
        cnt_d[k] = '0;
      end else if (cnt_q[k] == DB_MAX) begin
        deb_d[k] = sync_q[k];
        cnt_d[k] = '0;
      end else begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  assign rise = deb_q[0] & ~a_prev_q;
  assign sum  = {1'b0, level_q} + STEP_V;
  assign diff = {1'b0, level_q} - STEP_V;

  // A direct load always wins over a detent on the same edge.
  always_comb begin
    level_d = level_q;
    if (load_i) begin
      level_d = load_level_i;
    end else if (rise && !deb_q[1]) begin
      level_d = (SATURATE != 0 && sum[LEVEL_WIDTH]) ?
        '1 : sum[LEVEL_WIDTH-1:0];
    end else if (rise) begin
      level_d = (SATURATE != 0 && diff[LEVEL_WIDTH]) ?
        '0 : diff[LEVEL_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      meta_q   <= '0;
      sync_q   <= '0;
      deb_q    <= '0;
      cnt_q    <= '0;
      a_prev_q <= 1'b0;
      level_q  <= '0;
    end else begin
      meta_q   <= {enc_b_i, enc_a_i};
      sync_q   <= meta_q;
      deb_q    <= deb_d;
      cnt_q    <= cnt_d;
      a_prev_q <= deb_q[0];
      level_q  <= level_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pwm_mixer.sv
// Multi-channel rotary-encoder level mixer with shared-counter PWM outputs.
module pwm_mixer
  import pwm_mixer_pkg::*;
#(
  parameter int NUM_CH          = DEF_NUM_CH,
  parameter int LEVEL_WIDTH     = DEF_LEVEL_WIDTH,
  parameter int STEP            = DEF_STEP,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE,
  parameter int SATURATE        = DEF_SATURATE,
  parameter int INVERT          = DEF_INVERT
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_CH-1:0]             enc_a,
  input  logic [NUM_CH-1:0]             enc_b,
  input  logic                          load_valid,
  input  logic [ch_w(NUM_CH)-1:0]       load_ch,
  input  logic [LEVEL_WIDTH-1:0]        load_level,
  output logic [NUM_CH-1:0]             pwm_out,
  output logic [NUM_CH*LEVEL_WIDTH-1:0] level_out
);

  localparam int CH_W = ch_w(NUM_CH);
  localparam logic INV = (INVERT != 0);

  logic [NUM_CH-1:0][LEVEL_WIDTH-1:0] lvl;
  logic [NUM_CH-1:0] load_hit;
  logic [NUM_CH-1:0] pwm_q, pwm_d;
  logic [LEVEL_WIDTH-1:0] cnt_q;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign load_hit[i] = load_valid && (load_ch == CH_W'(i));

    mixer_channel #(
      .LEVEL_WIDTH    (LEVEL_WIDTH),
      .STEP           (STEP),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .SATURATE       (SATURATE)
    ) u_ch (
      .clk         (clk),
      .reset       (reset),
      .enc_a_i     (enc_a[i]),
      .enc_b_i     (enc_b[i]),
      .load_i      (load_hit[i]),
      .load_level_i(load_level),
      .level_o     (lvl[i])
    );
  end

  always_comb begin
    pwm_d = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      pwm_d[i] = (cnt_q < lvl[i]) ^ INV;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= {NUM_CH{INV}};
    end else begin
      cnt_q <= cnt_q + 1'b1;
      pwm_q <= pwm_d;
    end
  end

  assign pwm_out   = pwm_q;
  assign level_out = lvl;

endmodule

// File: tb/tb_pwm_mixer.sv
// Directed self-checking bench for pwm_mixer (saturating, wrapping, inverted).
module tb_pwm_mixer;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] enc_a, enc_b;
  logic       load_valid;
  logic [1:0] load_ch;
  logic [7:0] load_level;
  logic [2:0]  pwm_s, pwm_w, pwm_i;
  logic [23:0] lvl_s, lvl_w, lvl_i;

  int checks = 0;
  int errors = 0;
  int hi_s[3];
  int hi_i[3];

  always #5 clk = ~clk;

  pwm_mixer dut (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_ch(load_ch),
    .load_level(load_level), .pwm_out(pwm_s), .level_out(lvl_s)
  );

  pwm_mixer #(.SATURATE(0)) dut_w (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_ch(load_ch),
    .load_level(load_level), .pwm_out(pwm_w), .level_out(lvl_w)
  );

  pwm_mixer #(.INVERT(1)) dut_i (
    .clk(clk), .reset(reset), .enc_a(enc_a), .enc_b(enc_b),
    .load_valid(load_valid), .load_ch(load_ch),
    .load_level(load_level), .pwm_out(pwm_i), .level_out(lvl_i)
  );

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [1:0] ch, input logic [7:0] v);
    load_valid = 1'b1;
    load_ch    = ch;
    load_level = v;
    cyc(1);
    load_valid = 1'b0;
  endtask

  task automatic detent(input logic [2:0] mask, input logic down);
    enc_b = down ? mask : 3'b000;
    cyc(12);
    enc_a = mask;
    cyc(12);
    enc_a = 3'b000;
    cyc(12);
    enc_b = 3'b000;
    cyc(12);
  endtask

  initial begin
    reset = 1'b1;
    enc_a = '0;
    enc_b = '0;
    load_valid = 1'b0;
    load_ch = '0;
    load_level = '0;
    cyc(2);
    check("rst_pwm", 32'(pwm_s), 32'h0);
    check("rst_lvl", 32'(lvl_s), 32'h0);
    check("rst_pwm_inv", 32'(pwm_i), 32'h7);
    reset = 1'b0;

    cyc(256);
    check("idle_pwm", 32'(pwm_s), 32'h0);
    check("idle_lvl", 32'(lvl_s), 32'h0);

    // Bounce ch1 A, then hold high with B low.
    enc_a = 3'b010;
    cyc(1);
    enc_a = 3'b000;
    cyc(1);
    enc_a = 3'b010;
    cyc(9);
    check("deb_early", 32'(lvl_s), 32'h0);
    cyc(1);
    check("deb_on_time", 32'(lvl_s), 32'h000100);
    cyc(20);
    check("deb_no_extra", 32'(lvl_s), 32'h000100);
    enc_a = 3'b000;
    cyc(12);

    load(2'd0, 8'd254);
    check("load254", 32'(lvl_s[7:0]), 32'd254);
    detent(3'b001, 1'b0);
    detent(3'b001, 1'b0);
    detent(3'b001, 1'b0);
    check("sat_up", 32'(lvl_s[7:0]), 32'd255);
    check("wrap_up", 32'(lvl_w[7:0]), 32'd1);
    load(2'd0, 8'd1);
    detent(3'b001, 1'b1);
    detent(3'b001, 1'b1);
    check("sat_dn", 32'(lvl_s[7:0]), 32'd0);
    check("wrap_dn", 32'(lvl_w[7:0]), 32'd255);

    // Load and detent on ch0 share the same edge; ch2 detent is independent.
    enc_a = 3'b101;
    cyc(9);
    load_valid = 1'b1;
    load_ch    = 2'd0;
    load_level = 8'h80;
    cyc(1);
    load_valid = 1'b0;
    check("collide_s", 32'(lvl_s), 32'h010180);
    check("collide_w", 32'(lvl_w), 32'h010180);
    cyc(5);
    check("collide_hold", 32'(lvl_s), 32'h010180);
    enc_a = 3'b000;
    cyc(12);

    load(2'd3, 8'h55);
    check("oob_load", 32'(lvl_s), 32'h010180);

    load(2'd0, 8'd0);
    load(2'd1, 8'd64);
    load(2'd2, 8'd255);
    check("pwm_levels", 32'(lvl_i), 32'hFF4000);
    cyc(2);
    for (int c = 0; c < 3; c++) begin
      hi_s[c] = 0;
      hi_i[c] = 0;
    end
    for (int t = 0; t < 256; t++) begin
      cyc(1);
      for (int c = 0; c < 3; c++) begin
        hi_s[c] += int'(pwm_s[c]);
        hi_i[c] += int'(pwm_i[c]);
      end
    end
    check("duty0", 32'(hi_s[0]), 32'd0);
    check("duty64", 32'(hi_s[1]), 32'd64);
    check("duty255", 32'(hi_s[2]), 32'd255);
    check("duty0_inv", 32'(hi_i[0]), 32'd256);
    check("duty64_inv", 32'(hi_i[1]), 32'd192);
    check("duty255_inv", 32'(hi_i[2]), 32'd1);

    detent(3'b111, 1'b0);
    check("all_up_s", 32'(lvl_s), 32'hFF4101);
    check("all_up_w", 32'(lvl_w), 32'h004101);

    // Reset in the middle of an A debounce.
    enc_a = 3'b001;
    cyc(5);
    reset = 1'b1;
    #1;
    check("async_rst_lvl", 32'(lvl_s), 32'h0);
    check("async_rst_pwm", 32'(pwm_s), 32'h0);
    check("async_rst_inv", 32'(pwm_i), 32'h7);
    enc_a = 3'b000;
    cyc(3);
    reset = 1'b0;
    cyc(30);
    check("post_rst_lvl", 32'(lvl_s), 32'h0);
    check("post_rst_lvl_w", 32'(lvl_w), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_mixer.md
PWM_MIXER -- requirements
Module: pwm_mixer

Interface
REQ-001 Parameter NUM_CH, default 3, is the number of independent encoder-to-PWM channels, legal range 1..16.
REQ-002 Parameter LEVEL_WIDTH, default 8, is the level register and PWM counter width, legal range 2..16.
REQ-003 Parameter STEP, default 1, is the level change per detent, legal range 1..2^LEVEL_WIDTH-1.
REQ-004 Parameter DEBOUNCE_CYCLES, default 7, is the stable-cycle count required to accept an input change, legal range 1..255.
REQ-005 Parameter SATURATE, default 1: 1 means clamp at the level limits, 0 means wrap modulo 2^LEVEL_WIDTH.
REQ-006 Parameter INVERT, default 0: 1 means all PWM outputs are active-low.
REQ-007 clk  input  1  the single clock; all state is sampled on its rising edge.
REQ-008 reset  input  1  the reset is asynchronous and active-high.
REQ-009 enc_a  input  NUM_CH  encoder phase A per channel; asynchronous, bouncy.
REQ-010 enc_b  input  NUM_CH  encoder phase B per channel; asynchronous, bouncy.
REQ-011 load_valid  input  1  a single-cycle direct level write strobe.
REQ-012 load_ch  input  clog2(NUM_CH), min 1  target channel of the write; writes to out-of-range channels are ignored.
REQ-013 load_level  input  LEVEL_WIDTH  value written on load_valid.
REQ-014 pwm_out  output  NUM_CH  registered PWM output per channel.
REQ-015 level_out  output  NUM_CH*LEVEL_WIDTH  current levels; channel i occupies bits [i*LEVEL_WIDTH +: LEVEL_WIDTH].

Function
REQ-016 Each enc_a/enc_b bit SHALL pass a 2-flop synchroniser before any other use.
REQ-017 Each synchronised input SHALL have a debounced copy, which updates on the edge where the synchronised value has differed from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-018 The per-input debounce counter SHALL clear on any cycle where the synchronised value equals the debounced value.
REQ-019 A detent SHALL be a 0->1 transition of debounced A: debounced B=0 means increment by STEP; debounced B=1 means decrement by STEP.
REQ-020 A debounced transition of B alone, or a 1->0 transition of A, SHALL NOT change the level.
REQ-021 The level register SHALL update on the clock edge after the edge on which debounced A rose; level_out reflects that register directly.
REQ-022 With SATURATE=1: level+STEP > 2^LEVEL_WIDTH-1 SHALL give 2^LEVEL_WIDTH-1, and level < STEP on a decrement SHALL give 0.
REQ-023 With SATURATE=0, arithmetic SHALL be modulo 2^LEVEL_WIDTH.
REQ-024 load_valid SHALL write load_level into channel load_ch on the next edge.
REQ-025 If a load and a detent hit the same channel on the same cycle, the load SHALL win and the detent SHALL be discarded.
REQ-026 A single free-running LEVEL_WIDTH-bit counter, shared by all channels, SHALL count 0..2^LEVEL_WIDTH-1 and then wrap to 0.
REQ-027 pwm_out[i] SHALL be registered as (counter < level[i]) XOR INVERT.
REQ-028 Consequences of REQ-027: level 0 gives a constant inactive output, and level max gives an active output for (2^W-1) of every 2^W cycles.
REQ-029 Channels SHALL be fully independent; simultaneous detents on all channels SHALL all take effect on the same edge.

Reset
REQ-030 Asserting reset SHALL immediately clear all synchroniser flops, debounced values, debounce counters, levels and the PWM counter.
REQ-031 While reset is asserted, pwm_out SHALL be INVERT on every bit and level_out SHALL be 0.
REQ-032 Reset asserted mid-debounce or mid-detent SHALL discard the partial event; no level change may occur after deassertion from pre-reset activity.

Structure
REQ-033 The default parameter values and the load-channel width function SHALL live in the shared package pwm_mixer_pkg.
REQ-034 Sync, debounce, detent decode and the level register SHALL form one sub-module, mixer_channel, instantiated NUM_CH times.
REQ-035 The top level SHALL own the shared PWM counter, the load decode and the compare/output registers.

Verification
REQ-036 Reset with INVERT=0: pwm_out=0 and level_out=0; after 2^8 cycles with no stimulus, both remain 0.
REQ-037 Channel 1: bounce A for 3 cycles, then hold A=1 with B=0 -> level[1]=1 exactly 2+7+1 cycles after A became stable; no extra increments.
REQ-038 SATURATE=1: load 254 then 3 up detents -> level 255; load 1 then 2 down detents -> 0. With SATURATE=0, the same stimulus gives 1 and 255.
REQ-039 On the same cycle, load ch0=0x80 and deliver a ch0 up detent plus a ch2 up detent -> ch0=0x80 and ch2=1.
REQ-040 Levels 0, 64 and 255 -> pwm_out high for 0, 64 and 255 of each 256-cycle window; with INVERT=1 the counts are complemented.
REQ-041 Assert reset midway through an A debounce, release, hold inputs low -> level remains 0.
